// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: two-entry skid buffer between fetch and decode,
// with the held instruction split into decode fields.
//
// state | meaning
// EMPTY | no instruction held
// ONE   | main entry holds the presented instruction, skid empty
// FULL  | main holds the presented instruction, skid holds the next one
module if_id_stage #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [2:0]         opcode,
    output logic [2:0]         reg_a,
    output logic [2:0]         reg_b,
    output logic [2:0]         reg_c,
    output logic [6:0]         immediate,
    output logic [9:0]         long_immediate
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    main_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;
    logic               accept;
    logic               consume;
    logic               load_main_in;
    logic               load_main_skid;
    logic               clear_main;
    logic               load_skid;

    // Ready only looks at registered state (and reset), never at out_ready.
    assign in_ready  = (state != FULL) & ~rst;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and entry load/clear strobes; flush forces EMPTY.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        clear_main     = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (consume) begin
                    if (accept) begin
                        load_main_in = 1'b1;
                    end else begin
                        clear_main = 1'b1;
                        state_nxt  = EMPTY;
                    end
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // in_ready is low here, so no accept can coincide with the refill.
                if (consume) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // Entry payloads; empty entries are kept at zero so the field outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr <= '0;
            main_pc    <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_instr <= '0;
            main_pc    <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_main_in) begin
                main_instr <= in_instr;
                main_pc    <= in_pc;
            end else if (load_main_skid) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
            end else if (clear_main) begin
                main_instr <= '0;
                main_pc    <= '0;
            end
            if (load_skid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end else if (load_main_skid) begin
                skid_instr <= '0;
                skid_pc    <= '0;
            end
        end
    end

    assign out_pc         = main_pc;
    assign opcode         = main_instr[15:13];
    assign reg_a          = main_instr[12:10];
    assign reg_b          = main_instr[9:7];
    assign reg_c          = main_instr[2:0];
    assign immediate      = main_instr[6:0];
    assign long_immediate = main_instr[9:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, field split, streaming,
// backpressure, flush and asynchronous reset.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [2:0]  opcode;
    logic [2:0]  reg_a;
    logic [2:0]  reg_b;
    logic [2:0]  reg_c;
    logic [6:0]  immediate;
    logic [9:0]  long_immediate;

    int checks = 0;
    int errors = 0;

    if_id_stage #(.INSTR_W(16), .PC_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .opcode         (opcode),
        .reg_a          (reg_a),
        .reg_b          (reg_b),
        .reg_c          (reg_c),
        .immediate      (immediate),
        .long_immediate (long_immediate)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction on the outputs, rebuilt from the field slices.
    function automatic logic [15:0] out_instr();
        return {opcode, reg_a, long_immediate};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_instr"}, 32'(out_instr()), 32'd0);
        chk({tag, "_reg_c"}, 32'(reg_c), 32'd0);
        chk({tag, "_pc"}, 32'(out_pc), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'h1234, 16'h0100);

        // Reset held with traffic present.
        step();
        step();
        chk_empty("rst");
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 16'h0, 16'h0);
        step();
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Field split of 0xACC0 at pc 0x0010.
        drive(1'b1, 16'hACC0, 16'h0010);
        step();
        drive(1'b0, 16'h0, 16'h0);
        chk("fs_valid", 32'(out_valid), 32'd1);
        chk("fs_opcode", 32'(opcode), 32'd5);
        chk("fs_reg_a", 32'(reg_a), 32'd3);
        chk("fs_reg_b", 32'(reg_b), 32'd1);
        chk("fs_reg_c", 32'(reg_c), 32'd0);
        chk("fs_imm", 32'(immediate), 32'h40);
        chk("fs_limm", 32'(long_immediate), 32'h0C0);
        chk("fs_pc", 32'(out_pc), 32'h0010);
        out_ready = 1'b1;
        step();
        chk_empty("fs_drain");

        // Streaming: 8 back-to-back with out_ready high, 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h2000 * 16'(i) + 16'h0155 + 16'(i), 16'h0200 + 16'(2 * i));
            step();
            chk("st_ready", 32'(in_ready), 32'd1);
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_instr", 32'(out_instr()), 32'(16'h2000 * 16'(i) + 16'h0155 + 16'(i)));
            chk("st_pc", 32'(out_pc), 32'(16'h0200 + 16'(2 * i)));
        end
        drive(1'b0, 16'h0, 16'h0);
        step();
        chk_empty("st_end");

        // Backpressure: A0 presented, decode stalls 3 cycles.
        drive(1'b1, 16'hA000, 16'h0300);
        step();
        chk("bp_a0_pc", 32'(out_pc), 32'h0300);
        out_ready = 1'b0;
        drive(1'b1, 16'hA001, 16'h0302);
        step();
        chk("bp_h1_ready", 32'(in_ready), 32'd0);
        chk("bp_h1_pc", 32'(out_pc), 32'h0300);
        drive(1'b1, 16'hA002, 16'h0304);
        step();
        chk("bp_h2_ready", 32'(in_ready), 32'd0);
        chk("bp_h2_instr", 32'(out_instr()), 32'hA000);
        step();
        chk("bp_h3_ready", 32'(in_ready), 32'd0);
        chk("bp_h3_pc", 32'(out_pc), 32'h0300);
        out_ready = 1'b1;
        step();
        chk("bp_d1_ready", 32'(in_ready), 32'd1);
        chk("bp_d1_instr", 32'(out_instr()), 32'hA001);
        chk("bp_d1_pc", 32'(out_pc), 32'h0302);
        step();
        drive(1'b0, 16'h0, 16'h0);
        chk("bp_d2_valid", 32'(out_valid), 32'd1);
        chk("bp_d2_instr", 32'(out_instr()), 32'hA002);
        chk("bp_d2_pc", 32'(out_pc), 32'h0304);
        step();
        chk_empty("bp_end");

        // Flush while FULL with in_valid high.
        out_ready = 1'b0;
        drive(1'b1, 16'hB000, 16'h0400);
        step();
        drive(1'b1, 16'hB001, 16'h0402);
        step();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'hB002, 16'h0404);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk_empty("fl_full");
        chk("fl_full_ready2", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_full_after", 32'(out_valid), 32'd0);

        // Flush in ONE discards a same-cycle accepted instruction.
        drive(1'b1, 16'hC000, 16'h0500);
        step();
        drive(1'b1, 16'hC001, 16'h0502);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk_empty("fl_one");
        step();
        chk("fl_one_after", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        drive(1'b1, 16'hD000, 16'h0600);
        step();
        drive(1'b1, 16'hD001, 16'h0602);
        step();
        drive(1'b0, 16'h0, 16'h0);
        chk("ar_full_pc", 32'(out_pc), 32'h0600);
        #2;
        rst = 1'b1;
        #1;
        chk_empty("ar_mid");
        chk("ar_mid_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk_empty("ar_rel");
        chk("ar_rel_ready", 32'(in_ready), 32'd1);
        step();
        chk("ar_rel2_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
